neuron_mac_lanes: RTL
=====================

# neuron_mac_lanes

Parametrised fully-connected neuron that computes one output activation from PREV_COUNT inputs streamed LANES at a time. Each lane multiplies its input against a locally stored signed fixed-point weight and accumulates the result. A stored bias is then added, and the sum is rescaled, saturated and passed through a selectable activation. It sits in a layer array in place of the single-lane neuron, between the previous layer's output stream and the next layer's input stream.

## Interface
- PREV_COUNT, 169: number of inputs (weights) feeding this neuron.
- LANES, 1: inputs consumed per accepted beat; 1 ≤ LANES ≤ PREV_COUNT.
- IN_W, 17 / IN_FRAC, 14: signed input width / fractional bits.
- W_W, 16 / W_FRAC, 14: signed weight and bias width / fractional bits.
- OUT_W, 19 / OUT_FRAC, 14: signed output width / fractional bits; OUT_FRAC ≤ IN_FRAC+W_FRAC.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  weight/bias write strobe.
- wr_addr  in  clog2(PREV_COUNT+1)  0..PREV_COUNT-1 = weight index; PREV_COUNT = bias.
- wr_data  in  W_W  signed weight or bias value.
- weights_loaded  out  1  set by a bias write; cleared only by rst.
- act_mode  in  2  sampled at start: 0 identity, 1 ReLU, 2 ReLU clipped to +max, 3 same as 0.
- start  in  1  begin one evaluation (single-cycle pulse).
- abort  in  1  drop the current evaluation.
- in_valid / in_ready  in/out  1  input beat handshake.
- in_data  in  LANES*IN_W  lane k in bits [k*IN_W +: IN_W]; input index = beat*LANES+k.
- out_valid / out_ready  out/in  1  result handshake.
- out_data  out  OUT_W  activated result.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, PREFETCH, ACC, DRAIN, BIAS, OUT.
- IDLE: writes are accepted only here; a write in any other state is ignored. A write at an out-of-range address (> PREV_COUNT) is ignored.
- IDLE → PREFETCH on start && weights_loaded. The start is ignored otherwise, including when busy. The weight read for beat 0 is issued in PREFETCH.
- PREFETCH → ACC after 1 cycle. The accumulator is cleared.
- ACC: in_ready=1. On each in_valid&&in_ready:
  - the per-lane products are registered;
  - the read for the next beat is issued;
  - the beat counter increments.
- The accumulator adds the previous beat's registered products, summed over lanes. Lanes with index ≥ PREV_COUNT on the final beat contribute 0 regardless of data.
- ACC → DRAIN after beat NBEATS-1 = ceil(PREV_COUNT/LANES)-1 is accepted. in_ready drops in the same edge.
- DRAIN: the last products are accumulated and the bias read is issued.
- BIAS: the bias is sign-extended and shifted left by IN_FRAC, then added.
- OUT: the result is computed as follows:
  - arithmetic-shift the sum right by IN_FRAC+W_FRAC-OUT_FRAC (truncation, no rounding);
  - saturate to the OUT_W signed range;
  - apply the activation.
- OUT holds out_valid=1 with out_data stable until out_ready, then goes to IDLE.
- Widths:
  - product is IN_W+W_W bits;
  - the accumulator is IN_W+W_W+clog2(PREV_COUNT+1) bits, so it never overflows;
  - saturation happens only at output.
- abort in any non-IDLE state forces IDLE on the next edge. The accumulator is cleared, no out_valid is produced, and weights are kept. abort in IDLE has no effect. abort has priority over a simultaneous handshake.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, weights_loaded=0, state IDLE. Weight RAM contents are not reset.
- start at edge t gives in_ready=1 from cycle t+2.
- With in_valid held high, beats are accepted every cycle (full throughput). Backpressure is only from in_valid gaps.
- Latency: last beat accepted at edge t gives out_valid=1 at cycle t+3 (DRAIN, BIAS, OUT).
- A write in IDLE at edge t is readable by a start issued at edge t+1 or later.
- out_valid && out_ready at edge t returns to IDLE. A start at t+1 is accepted; a start at the same edge t is ignored.

## Structure
- Shared package neuron_pkg: act_mode encodings (ACT_ID, ACT_RELU, ACT_RELU_CLIP), the state enum, and a clog2 helper.
- Sub-module neuron_weight_bank:
  - LANES banks, each of depth NBEATS, plus a bias register;
  - synchronous write;
  - registered read, 1-cycle latency.
- Activation/saturation is a combinational function in the package.

## Test plan
- Basic sum:
  - config PREV_COUNT=4, LANES=2, all widths 8, all FRAC 4, act_mode=1;
  - weights 0x08 (0.5), bias 0x04 (0.25), inputs 0x10 (1.0), two back-to-back beats;
  - expect out_data=0x24 (2.25) exactly 3 cycles after the second beat.
- Negative sum:
  - same config with weights 0xF8 (-0.5);
  - act_mode=0 gives 0xE4 (-1.75); act_mode=1 gives 0x00.
- Saturation:
  - same config, weights 0x7F, inputs 0x7F, bias 0x7F;
  - act_mode=0 gives 0x7F; act_mode=2 gives 0x7F.
  - With all weights 0x80 and inputs 0x7F, act_mode=0 gives 0x80.
- Partial lane:
  - PREV_COUNT=3, LANES=2, weights all 0x10;
  - second beat lane 1 = 0x7F must be ignored; expect the sum of three inputs plus bias only.
- Abort and stall:
  - abort after the first beat: no out_valid, state IDLE next cycle;
  - a restart with out_ready held low for 5 cycles keeps out_data stable, then completes correctly.
- Reset and gating:
  - rst asserted mid-ACC clears all outputs asynchronously and clears weights_loaded;
  - a subsequent start is ignored until the bias is rewritten; writes during busy are ignored.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the lane-parallel neuron: activation encodings,
// controller states, a constant log2 helper and the output rescale/activate function.
package neuron_pkg;

    typedef enum logic [1:0] {
        ACT_ID        = 2'd0,
        ACT_RELU      = 2'd1,
        ACT_RELU_CLIP = 2'd2,
        ACT_ID_ALT    = 2'd3
    } act_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_ACC,
        ST_DRAIN,
        ST_BIAS,
        ST_OUT
    } state_e;

    // Ceil log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int v);
        int n;
        n = 0;
        while ((1 << n) < v) n++;
        return (n < 1) ? 1 : n;
    endfunction

    // Truncating rescale, saturation to out_w signed bits, then activation.
    // Saturation already bounds the top, so the clipped ReLU only differs in name.
    function automatic logic signed [63:0] act_sat(input logic signed [63:0] v,
                                                   input int shift,
                                                   input int out_w,
                                                   input logic [1:0] mode);
        logic signed [63:0] s;
        logic signed [63:0] vmax;
        logic signed [63:0] vmin;
        s    = v >>> shift;
        vmax = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        vmin = -(64'sd1 <<< (out_w - 1));
        if (s > vmax) begin
            s = vmax;
        end else if (s < vmin) begin
            s = vmin;
        end
        if ((mode == ACT_RELU || mode == ACT_RELU_CLIP) && s < 64'sd0) begin
            s = '0;
        end
        return s;
    endfunction

endpackage

// File: rtl/neuron_weight_bank.sv
// Per-lane weight RAMs (weight i lives in bank i%LANES, row i/LANES) plus the bias
// register; writes are synchronous and both reads have one cycle of latency.
module neuron_weight_bank
    import neuron_pkg::*;
#(
    parameter int PREV_COUNT = 169,
    parameter int LANES      = 1,
    parameter int W_W        = 16
) (
    input  logic                                clk,
    input  logic                                i_wr_en,
    input  logic [clog2(PREV_COUNT + 1)-1:0]    i_wr_addr,
    input  logic [W_W-1:0]                      i_wr_data,
    input  logic                                i_rd_en,
    input  logic [clog2((PREV_COUNT + LANES - 1) / LANES)-1:0] i_rd_row,
    input  logic                                i_rd_bias,
    output logic [LANES*W_W-1:0]                o_rd_data,
    output logic [W_W-1:0]                      o_bias
);
    localparam int NBEATS = (PREV_COUNT + LANES - 1) / LANES;
    localparam int ADDR_W = clog2(PREV_COUNT + 1);
    localparam int ROW_W  = clog2(NBEATS);
    localparam int LANE_W = clog2(LANES);

    logic              w_is_weight;
    logic [LANE_W-1:0] w_lane;
    logic [ROW_W-1:0]  w_row;
    logic [W_W-1:0]    r_bias;
    logic [W_W-1:0]    r_bias_q;

    assign w_is_weight = i_wr_en && (i_wr_addr < ADDR_W'(PREV_COUNT));
    assign w_lane      = LANE_W'(i_wr_addr % ADDR_W'(LANES));
    assign w_row       = ROW_W'(i_wr_addr / ADDR_W'(LANES));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_bank
            logic [W_W-1:0] r_mem [NBEATS];
            logic [W_W-1:0] r_rd;
            always_ff @(posedge clk) begin
                if (w_is_weight && w_lane == LANE_W'(gi)) begin
                    r_mem[w_row] <= i_wr_data;
                end
                if (i_rd_en) begin
                    r_rd <= r_mem[i_rd_row];
                end
            end
            assign o_rd_data[gi*W_W +: W_W] = r_rd;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_addr == ADDR_W'(PREV_COUNT)) begin
            r_bias <= i_wr_data;
        end
        if (i_rd_bias) begin
            r_bias_q <= r_bias;
        end
    end

    assign o_bias = r_bias_q;

endmodule

// File: rtl/neuron_mac_lanes.sv
// Fully-connected neuron: LANES inputs per beat are multiplied by stored weights and
// accumulated, then bias is added and the sum is rescaled, saturated and activated.
module neuron_mac_lanes
    import neuron_pkg::*;
#(
    parameter int PREV_COUNT = 169,
    parameter int LANES      = 1,
    parameter int IN_W       = 17,
    parameter int IN_FRAC    = 14,
    parameter int W_W        = 16,
    parameter int W_FRAC     = 14,
    parameter int OUT_W      = 19,
    parameter int OUT_FRAC   = 14
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [clog2(PREV_COUNT + 1)-1:0] wr_addr,
    input  logic [W_W-1:0]                   wr_data,
    output logic                             weights_loaded,
    input  logic [1:0]                       act_mode,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*IN_W-1:0]            in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W-1:0]                 out_data,
    output logic                             busy
);
    localparam int NBEATS     = (PREV_COUNT + LANES - 1) / LANES;
    localparam int ADDR_W     = clog2(PREV_COUNT + 1);
    localparam int BEAT_W     = clog2(NBEATS);
    localparam int PROD_W     = IN_W + W_W;
    localparam int ACC_W      = PROD_W + clog2(PREV_COUNT + 1);
    localparam int LAST_LANES = PREV_COUNT - (NBEATS - 1) * LANES;
    localparam int SHIFT      = IN_FRAC + W_FRAC - OUT_FRAC;

    state_e                   r_state;
    state_e                   w_state_next;
    logic [BEAT_W-1:0]        r_beat;
    logic                     r_prod_vld;
    logic signed [PROD_W-1:0] r_prod [LANES];
    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_lane_sum;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_with_bias;
    logic [1:0]               r_mode;
    logic                     r_loaded;
    logic [OUT_W-1:0]         r_out;

    logic                     w_wr_ok;
    logic                     w_accept;
    logic                     w_last_beat;
    logic                     w_rd_en;
    logic [BEAT_W-1:0]        w_rd_row;
    logic                     w_rd_bias;
    logic [LANES*W_W-1:0]     w_rd_data;
    logic [W_W-1:0]           w_bias_q;

    assign w_wr_ok     = wr_en && (r_state == ST_IDLE);
    assign w_accept    = (r_state == ST_ACC) && in_valid && !abort;
    assign w_last_beat = (r_beat == BEAT_W'(NBEATS - 1));

    neuron_weight_bank #(
        .PREV_COUNT (PREV_COUNT),
        .LANES      (LANES),
        .W_W        (W_W)
    ) u_bank (
        .clk        (clk),
        .i_wr_en    (w_wr_ok),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rd_en    (w_rd_en),
        .i_rd_row   (w_rd_row),
        .i_rd_bias  (w_rd_bias),
        .o_rd_data  (w_rd_data),
        .o_bias     (w_bias_q)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [IN_W-1:0]   w_x;
            logic signed [W_W-1:0]    w_w;
            logic signed [PROD_W-1:0] w_mul;
            assign w_x   = in_data[gi*IN_W +: IN_W];
            assign w_w   = w_rd_data[gi*W_W +: W_W];
            assign w_mul = PROD_W'(w_x) * PROD_W'(w_w);
            // Lanes past PREV_COUNT on the final beat hold unwritten weights.
            if (gi >= LAST_LANES) begin : g_tail
                assign w_prod[gi] = w_last_beat ? '0 : w_mul;
            end else begin : g_full
                assign w_prod[gi] = w_mul;
            end
        end
    endgenerate

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_sum = w_lane_sum + ACC_W'(r_prod[k]);
        end
    end

    assign w_bias_ext  = ACC_W'($signed(w_bias_q));
    assign w_with_bias = r_acc + (w_bias_ext <<< IN_FRAC);

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_rd_row     = '0;
        w_rd_bias    = 1'b0;
        case (r_state)
            ST_IDLE:     if (start && r_loaded) w_state_next = ST_PREFETCH;
            ST_PREFETCH: begin
                w_rd_en      = 1'b1;
                w_state_next = ST_ACC;
            end
            ST_ACC: begin
                if (w_accept) begin
                    w_rd_en  = !w_last_beat;
                    w_rd_row = r_beat + BEAT_W'(1);
                    if (w_last_beat) w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_rd_bias    = 1'b1;
                w_state_next = ST_BIAS;
            end
            ST_BIAS:     w_state_next = ST_OUT;
            ST_OUT:      if (out_ready) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
        if (abort && r_state != ST_IDLE) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_mode     <= '0;
            r_loaded   <= 1'b0;
            r_out      <= '0;
            for (int k = 0; k < LANES; k++) r_prod[k] <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_wr_ok && wr_addr == ADDR_W'(PREV_COUNT)) r_loaded <= 1'b1;
            if (r_state == ST_IDLE && start && r_loaded) r_mode <= act_mode;
            if (abort && r_state != ST_IDLE) begin
                r_acc      <= '0;
                r_prod_vld <= 1'b0;
            end else begin
                case (r_state)
                    ST_PREFETCH: begin
                        r_acc      <= '0;
                        r_beat     <= '0;
                        r_prod_vld <= 1'b0;
                    end
                    ST_ACC: begin
                        if (r_prod_vld) r_acc <= r_acc + w_lane_sum;
                        r_prod_vld <= w_accept;
                        if (w_accept) begin
                            for (int k = 0; k < LANES; k++) r_prod[k] <= w_prod[k];
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (r_prod_vld) r_acc <= r_acc + w_lane_sum;
                        r_prod_vld <= 1'b0;
                    end
                    ST_BIAS: begin
                        r_acc <= w_with_bias;
                        r_out <= OUT_W'(act_sat(64'(w_with_bias), SHIFT, OUT_W, r_mode));
                    end
                    default: ;
                endcase
            end
        end
    end

    assign weights_loaded = r_loaded;
    assign in_ready       = (r_state == ST_ACC);
    assign out_valid      = (r_state == ST_OUT);
    assign busy           = (r_state != ST_IDLE);
    assign out_data       = r_out;

endmodule
